// File: rtl/hazard_ctrl_mc.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline.
// Handles multi-cycle load-use stalls, multi-cycle redirect flushes and EX operand forwarding.
module hazard_ctrl_mc #(
    parameter int WIDTH       = 32,
    parameter int LOAD_LAT    = 2,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instruction_d,
    input  logic [WIDTH-1:0] instruction_ex,
    input  logic [WIDTH-1:0] instruction_mem,
    input  logic [WIDTH-1:0] instruction_wb,
    input  logic             br_taken,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             busy
);

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [2:0] LOAD_CNT  = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_FLUSH     = 2'd2
    } state_t;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_OPIMM, OP_OP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: writes_rd = 1'b1;
            default:                                                     writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL: reads_rs1 = 1'b0;
            default:                  reads_rs1 = 1'b1;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        case (op)
            OP_OP, OP_STORE, OP_BRANCH: reads_rs2 = 1'b1;
            default:                    reads_rs2 = 1'b0;
        endcase
    endfunction

    logic [6:0] op_d, op_ex, op_mem, op_wb;
    logic [4:0] rs1_d, rs2_d, rd_ex, rs1_ex, rs2_ex, rd_mem, rd_wb;

    assign op_d   = instruction_d[6:0];
    assign rs1_d  = instruction_d[19:15];
    assign rs2_d  = instruction_d[24:20];
    assign op_ex  = instruction_ex[6:0];
    assign rd_ex  = instruction_ex[11:7];
    assign rs1_ex = instruction_ex[19:15];
    assign rs2_ex = instruction_ex[24:20];
    assign op_mem = instruction_mem[6:0];
    assign rd_mem = instruction_mem[11:7];
    assign op_wb  = instruction_wb[6:0];
    assign rd_wb  = instruction_wb[11:7];

    logic unused_bits_s;
    assign unused_bits_s = ^{instruction_d[14:7], instruction_d[WIDTH-1:25],
                             instruction_ex[14:12], instruction_ex[WIDTH-1:25],
                             instruction_mem[WIDTH-1:12], instruction_wb[WIDTH-1:12]};

    // MEM loads are excluded: their data is not available until WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic rd_used);
        if (!rd_used) begin
            fwd_sel = 2'b00;
        end else if (writes_rd(op_mem) && (rd_mem != 5'd0) && (rd_mem == rs) && (op_mem != OP_LOAD)) begin
            fwd_sel = 2'b01;
        end else if (writes_rd(op_wb) && (rd_wb != 5'd0) && (rd_wb == rs)) begin
            fwd_sel = 2'b10;
        end else begin
            fwd_sel = 2'b00;
        end
    endfunction

    logic load_use_s, redirect_s;
    assign load_use_s = (op_ex == OP_LOAD) && (rd_ex != 5'd0) &&
                        ((reads_rs1(op_d) && (rs1_d == rd_ex)) ||
                         (reads_rs2(op_d) && (rs2_d == rd_ex)));
    assign redirect_s = (op_ex == OP_JAL) || (op_ex == OP_JALR) ||
                        ((op_ex == OP_BRANCH) && br_taken);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       stall_s, flush_s;

    // State and window counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the first cycle of each window is signalled from IDLE itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_s = 1'b0;
        flush_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect_s) begin
                    flush_s = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_CNT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (load_use_s) begin
                    stall_s = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = ST_LOAD_WAIT;
                        cnt_d   = LOAD_CNT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_WAIT: begin
                stall_s = 1'b1;
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD_WAIT;
                end
            end
            ST_FLUSH: begin
                flush_s = 1'b1;
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    assign stall = stall_s & ~rst;
    assign flush = flush_s & ~rst;
    assign busy  = (state_q != ST_IDLE) & ~rst;
    assign fwd_a = rst ? 2'b00 : fwd_sel(rs1_ex, reads_rs1(op_ex));
    assign fwd_b = rst ? 2'b00 : fwd_sel(rs2_ex, reads_rs2(op_ex));

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: three instances with different window sizes share stimulus.
module tb_hazard_ctrl_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_d, i_ex, i_mem, i_wb;
    logic        br;

    logic       st_a, fl_a, bz_a, st_b, fl_b, bz_b, st_c, fl_c, bz_c;
    logic [1:0] fa_a, fb_a, fa_b, fb_b, fa_c, fb_c;

    always #5 clk = ~clk;

    hazard_ctrl_mc #(.WIDTH(32), .LOAD_LAT(2), .FLUSH_DEPTH(3)) u_a (
        .clk(clk), .rst(rst), .instruction_d(i_d), .instruction_ex(i_ex),
        .instruction_mem(i_mem), .instruction_wb(i_wb), .br_taken(br),
        .stall(st_a), .flush(fl_a), .fwd_a(fa_a), .fwd_b(fb_a), .busy(bz_a));
    hazard_ctrl_mc #(.WIDTH(32), .LOAD_LAT(1), .FLUSH_DEPTH(1)) u_b (
        .clk(clk), .rst(rst), .instruction_d(i_d), .instruction_ex(i_ex),
        .instruction_mem(i_mem), .instruction_wb(i_wb), .br_taken(br),
        .stall(st_b), .flush(fl_b), .fwd_a(fa_b), .fwd_b(fb_b), .busy(bz_b));
    hazard_ctrl_mc #(.WIDTH(32), .LOAD_LAT(4), .FLUSH_DEPTH(2)) u_c (
        .clk(clk), .rst(rst), .instruction_d(i_d), .instruction_ex(i_ex),
        .instruction_mem(i_mem), .instruction_wb(i_wb), .br_taken(br),
        .stall(st_c), .flush(fl_c), .fwd_a(fa_c), .fwd_b(fb_c), .busy(bz_c));

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] LW_X5    = 32'h0000_A283;
    localparam logic [31:0] ADD_X5   = 32'h0022_8333;
    localparam logic [31:0] LW_X0    = 32'h0000_A003;
    localparam logic [31:0] ADD_X0X0 = 32'h0000_0333;
    localparam logic [31:0] BEQ      = 32'h0000_0063;
    localparam logic [31:0] JAL      = 32'h0000_006F;
    localparam logic [31:0] ADD_X7   = 32'h0020_83B3;
    localparam logic [31:0] SUB_X7   = 32'h4073_8433;
    localparam logic [31:0] LW_X7    = 32'h0000_A383;
    localparam logic [31:0] ADD_RD0  = 32'h0020_8033;
    localparam logic [31:0] SW_X9    = 32'h0093_A023;
    localparam logic [31:0] ADD_X9   = 32'h0020_84B3;
    localparam logic [31:0] LUI_X9   = 32'h0000_04B7;

    typedef struct {
        string      name;
        logic [6:0] ea;
        logic [6:0] eb;
        logic [6:0] ec;
    } exp_t;

    exp_t queue_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [6:0] e(input logic s, input logic f, input logic b,
                                     input logic [1:0] fa, input logic [1:0] fb);
        e = {s, f, b, fa, fb};
    endfunction

    localparam logic [6:0] Z = 7'd0;

    // Monitor: outputs are valid every cycle; compare mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (queue_q.size() > 0) begin
            exp_t x;
            logic [6:0] act_a, act_b, act_c;
            x = queue_q.pop_front();
            act_a = {st_a, fl_a, bz_a, fa_a, fb_a};
            act_b = {st_b, fl_b, bz_b, fa_b, fb_b};
            act_c = {st_c, fl_c, bz_c, fa_c, fb_c};
            checks = checks + 3;
            if (act_a !== x.ea) begin
                errors = errors + 1;
                $display("FAIL %s inst_a {stall,flush,busy,fa,fb} got %b want %b", x.name, act_a, x.ea);
            end
            if (act_b !== x.eb) begin
                errors = errors + 1;
                $display("FAIL %s inst_b {stall,flush,busy,fa,fb} got %b want %b", x.name, act_b, x.eb);
            end
            if (act_c !== x.ec) begin
                errors = errors + 1;
                $display("FAIL %s inst_c {stall,flush,busy,fa,fb} got %b want %b", x.name, act_c, x.ec);
            end
        end
    end

    task automatic cyc(input string nm, input logic [31:0] d, input logic [31:0] ex,
                       input logic [31:0] mem, input logic [31:0] wb, input logic b,
                       input logic r, input logic [6:0] ea, input logic [6:0] eb,
                       input logic [6:0] ec);
        exp_t x;
        @(posedge clk);
        #1;
        i_d = d; i_ex = ex; i_mem = mem; i_wb = wb; br = b; rst = r;
        x.name = nm; x.ea = ea; x.eb = eb; x.ec = ec;
        queue_q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; i_d = ADD_X5; i_ex = LW_X5; i_mem = NOP; i_wb = NOP; br = 1'b0;

        // Reset holds everything low even with a hazard present.
        cyc("rst0", ADD_X5, LW_X5, NOP, NOP, 1'b0, 1'b1, Z, Z, Z);
        cyc("rst1", ADD_X5, LW_X5, NOP, NOP, 1'b0, 1'b1, Z, Z, Z);
        cyc("idle", NOP, NOP, NOP, NOP, 1'b0, 1'b0, Z, Z, Z);

        // Load-use window sizes 2 / 1 / 4.
        cyc("lu_c0", ADD_X5, LW_X5, NOP, NOP, 1'b0, 1'b0, e(1,0,0,2'd0,2'd0), e(1,0,0,2'd0,2'd0), e(1,0,0,2'd0,2'd0));
        cyc("lu_c1", ADD_X5, NOP, NOP, NOP, 1'b0, 1'b0, e(1,0,1,2'd0,2'd0), Z, e(1,0,1,2'd0,2'd0));
        cyc("lu_c2", ADD_X5, NOP, NOP, NOP, 1'b0, 1'b0, Z, Z, e(1,0,1,2'd0,2'd0));
        cyc("lu_c3", ADD_X5, NOP, NOP, NOP, 1'b0, 1'b0, Z, Z, e(1,0,1,2'd0,2'd0));
        cyc("lu_c4", ADD_X5, NOP, NOP, NOP, 1'b0, 1'b0, Z, Z, Z);

        // Load into x0 never stalls.
        cyc("lu_x0", ADD_X0X0, LW_X0, NOP, NOP, 1'b0, 1'b0, Z, Z, Z);
        cyc("lu_x0_after", ADD_X0X0, NOP, NOP, NOP, 1'b0, 1'b0, Z, Z, Z);

        // Taken branch: flush windows 3 / 1 / 2.
        cyc("beq_c0", NOP, BEQ, NOP, NOP, 1'b1, 1'b0, e(0,1,0,2'd0,2'd0), e(0,1,0,2'd0,2'd0), e(0,1,0,2'd0,2'd0));
        cyc("beq_c1", NOP, NOP, NOP, NOP, 1'b0, 1'b0, e(0,1,1,2'd0,2'd0), Z, e(0,1,1,2'd0,2'd0));
        cyc("beq_c2", NOP, NOP, NOP, NOP, 1'b0, 1'b0, e(0,1,1,2'd0,2'd0), Z, Z);
        cyc("beq_c3", NOP, NOP, NOP, NOP, 1'b0, 1'b0, Z, Z, Z);
        cyc("beq_nt", NOP, BEQ, NOP, NOP, 1'b0, 1'b0, Z, Z, Z);

        // Back-to-back jal: the second one is ignored while a window is open.
        cyc("jal_c0", NOP, JAL, NOP, NOP, 1'b0, 1'b0, e(0,1,0,2'd0,2'd0), e(0,1,0,2'd0,2'd0), e(0,1,0,2'd0,2'd0));
        cyc("jal_c1", NOP, JAL, NOP, NOP, 1'b0, 1'b0, e(0,1,1,2'd0,2'd0), e(0,1,0,2'd0,2'd0), e(0,1,1,2'd0,2'd0));
        cyc("jal_c2", NOP, NOP, NOP, NOP, 1'b0, 1'b0, e(0,1,1,2'd0,2'd0), Z, Z);
        cyc("jal_c3", NOP, NOP, NOP, NOP, 1'b0, 1'b0, Z, Z, Z);

        // Forwarding selects.
        cyc("fwd_mem", NOP, SUB_X7, ADD_X7, ADD_X7, 1'b0, 1'b0, e(0,0,0,2'd1,2'd1), e(0,0,0,2'd1,2'd1), e(0,0,0,2'd1,2'd1));
        cyc("fwd_wb", NOP, SUB_X7, LW_X7, ADD_X7, 1'b0, 1'b0, e(0,0,0,2'd2,2'd2), e(0,0,0,2'd2,2'd2), e(0,0,0,2'd2,2'd2));
        cyc("fwd_x0", NOP, SUB_X7, ADD_RD0, ADD_RD0, 1'b0, 1'b0, Z, Z, Z);
        cyc("fwd_sw", NOP, SW_X9, NOP, ADD_X9, 1'b0, 1'b0, e(0,0,0,2'd0,2'd2), e(0,0,0,2'd0,2'd2), e(0,0,0,2'd0,2'd2));
        cyc("fwd_lui", NOP, LUI_X9, NOP, ADD_X9, 1'b0, 1'b0, Z, Z, Z);

        // Reset aborts an open stall window; detection resumes afterwards.
        cyc("rw_c0", ADD_X5, LW_X5, NOP, NOP, 1'b0, 1'b0, e(1,0,0,2'd0,2'd0), e(1,0,0,2'd0,2'd0), e(1,0,0,2'd0,2'd0));
        cyc("rw_rst", ADD_X5, NOP, NOP, NOP, 1'b0, 1'b1, Z, Z, Z);
        cyc("rw_rel", ADD_X5, NOP, NOP, NOP, 1'b0, 1'b0, Z, Z, Z);
        cyc("rw_idle", ADD_X5, NOP, NOP, NOP, 1'b0, 1'b0, Z, Z, Z);
        cyc("rw_lu0", ADD_X5, LW_X5, NOP, NOP, 1'b0, 1'b0, e(1,0,0,2'd0,2'd0), e(1,0,0,2'd0,2'd0), e(1,0,0,2'd0,2'd0));
        cyc("rw_lu1", ADD_X5, NOP, NOP, NOP, 1'b0, 1'b0, e(1,0,1,2'd0,2'd0), Z, e(1,0,1,2'd0,2'd0));
        cyc("rw_lu2", ADD_X5, NOP, NOP, NOP, 1'b0, 1'b0, Z, Z, e(1,0,1,2'd0,2'd0));
        cyc("rw_lu3", ADD_X5, NOP, NOP, NOP, 1'b0, 1'b0, Z, Z, e(1,0,1,2'd0,2'd0));
        cyc("rw_lu4", ADD_X5, NOP, NOP, NOP, 1'b0, 1'b0, Z, Z, Z);

        for (int k = 0; k < 10 && queue_q.size() > 0; k++) begin
            @(posedge clk);
        end
        if (queue_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending=%0d want 0", queue_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
Parametrised hazard and forwarding controller for the 5-stage RV32I pipeline. It generalises the single-bubble load-use and branch-flush logic in three ways:
- load-use stalls are sized to a configurable data-memory latency;
- flushes are sized to a configurable front-end depth;
- EX-stage operand forwarding selects are generated from MEM and WB.
A small FSM with a down-counter holds multi-cycle stall and flush windows after the triggering instruction has left EX.

Parameters:
WIDTH, 32, instruction width.
LOAD_LAT, 2, total stall cycles per load-use hazard; legal range 1..7.
FLUSH_DEPTH, 2, total flush cycles per redirect; legal range 1..3.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
instruction_d  input  WIDTH  instruction in ID.
instruction_ex  input  WIDTH  instruction in EX.
instruction_mem  input  WIDTH  instruction in MEM.
instruction_wb  input  WIDTH  instruction in WB.
br_taken  input  1  branch condition resolved in EX for the EX instruction.
stall  output  1  hold PC and IF/ID; inject bubble into ID/EX.
flush  output  1  squash IF/ID and ID/EX.
fwd_a  output  2  EX rs1 source: 00 regfile, 01 MEM ALU result, 10 WB result.
fwd_b  output  2  EX rs2 source; same encoding as fwd_a.
busy  output  1  FSM is not in IDLE.

Behaviour:
- Field decode: rd=[11:7], rs1=[19:15], rs2=[24:20], opcode=[6:0].
- Writes rd: opcodes 03, 13, 33, 37, 17, 6F, 67.
- Reads rs1: all opcodes except 37, 17, 6F.
- Reads rs2: opcodes 33, 23, 63.
- load_use: EX opcode==03 AND rd_ex!=0 AND (rd_ex matches a register that the ID instruction reads).
- redirect: EX opcode is 6F or 67, OR (EX opcode==63 AND br_taken).
- FSM states: IDLE, LOAD_WAIT, FLUSH. 3-bit counter cnt.
- IDLE:
  - redirect: flush=1 this cycle. If FLUSH_DEPTH>1, go to FLUSH with cnt=FLUSH_DEPTH-1.
  - else if load_use: stall=1 this cycle. If LOAD_LAT>1, go to LOAD_WAIT with cnt=LOAD_LAT-1.
  - redirect and load_use cannot both hold, since EX contains one opcode. Redirect has priority regardless.
- LOAD_WAIT: stall=1, flush=0. Decrement cnt each cycle; go to IDLE on the edge where cnt==1.
- FLUSH: flush=1, stall=0. Decrement cnt each cycle; go to IDLE on the edge where cnt==1.
- Exact window lengths: stall is high for exactly LOAD_LAT consecutive cycles; flush is high for exactly FLUSH_DEPTH consecutive cycles.
- New load_use or redirect detections while not in IDLE are ignored; EX holds bubbles during these windows.
- busy = (state != IDLE).
- Forwarding, evaluated for rs1_ex (fwd_a) and rs2_ex (fwd_b), only when the EX instruction reads that source:
  - 01 if MEM writes rd, rd_mem!=0, rd_mem==rs, and MEM opcode!=03;
  - else 10 if WB writes rd, rd_wb!=0, rd_wb==rs;
  - else 00.
  - MEM has priority over WB.
  - Forwarding is purely combinational and independent of FSM state.
- Reset:
  - While rst=1: state=IDLE, cnt=0, and stall, flush, busy, fwd_a, fwd_b are all forced to 0.
  - Asserting rst mid-window aborts the window immediately.
  - After release, the FSM resumes detection from IDLE on the next cycle.

Test Plan:
- LOAD_LAT=2; EX=lw x5,0(x1); ID=add x6,x5,x2 -> stall high 2 cycles, busy high in cycle 2 only, flush 0.
- LOAD_LAT=1; EX=lw x0,0(x1); ID reads x0 -> stall never asserts.
- FLUSH_DEPTH=3; EX=beq, br_taken=1 -> flush high 3 cycles. Same with br_taken=0 -> flush 0. EX=jal -> flush 3 cycles with br_taken ignored.
- MEM=add x7,…; WB=add x7,…; EX=sub x8,x7,x7 -> fwd_a=fwd_b=01. Change MEM to lw x7 -> both 10. Change rd to x0 -> both 00.
- EX=sw x9,0(x7) with WB writing x9 -> fwd_b=10, fwd_a=00. EX=lui x9 -> both 00.
- LOAD_LAT=4; assert rst in the 2nd stall cycle -> stall=0 and busy=0 in the same cycle. Release rst with EX=bubble -> outputs stay 0.
